pdm_demod: RTL and testbench
============================

PDM_DEMOD -- requirements
Module: pdm_demod

Interface
REQ-001 The module SHALL have parameter OUTPUT_WIDTH, default 8, giving the output sample width in bits (unsigned).
REQ-002 The module SHALL have parameter DEC_LOG2, default 5, giving decimation ratio R = 2^DEC_LOG2; legal only when 2*DEC_LOG2 >= OUTPUT_WIDTH.
REQ-003 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-low reset: low at a clk edge resets the block.
REQ-005 Port pdm_in, input, 1, PDM bitstream; 1 = full scale, 0 = zero (unipolar).
REQ-006 Port bit_en, input, 1, qualifier; pdm_in is consumed only on cycles where bit_en = 1.
REQ-007 Port sample, output, OUTPUT_WIDTH, decimated unsigned sample.
REQ-008 Port sample_valid, output, 1, sample holds an unconsumed value.
REQ-009 Port sample_ready, input, 1, consumer accepts sample when sample_valid = 1 and sample_ready = 1.
REQ-010 Port overrun, output, 1, sticky flag: an unconsumed sample was overwritten.

Function
REQ-011 The filter SHALL be a 2nd-order CIC, differential delay 1, decimation R, internal width W = 2*DEC_LOG2+1.
REQ-012 Integrator 1 SHALL add pdm_in (0/1) on each bit_en cycle; integrator 2 SHALL add integrator 1's pre-update value on the same cycles; neither changes when bit_en = 0.
REQ-013 Integrators and combs SHALL use modulo-2^W wrap-around arithmetic; wrap is legal and SHALL NOT be detected or saturated.
REQ-014 A decimation counter SHALL count bit_en cycles 0..R-1 and wrap to 0; the bit_en cycle at count R-1 is the decimation tick.
REQ-015 On the cycle after a tick, two cascaded comb stages SHALL compute y = c - c_prev on integrator 2's value and update their delay registers.
REQ-016 The full-precision result y (0..R^2) SHALL be scaled as min(y >> (2*DEC_LOG2 - OUTPUT_WIDTH), 2^OUTPUT_WIDTH - 1), saturating, never wrapping.
REQ-017 The scaled value SHALL be loaded into sample, with sample_valid = 1, at the edge ending the second cycle after the tick; latency is 2 clk cycles from the tick edge.
REQ-018 The first 2 decimated results after reset SHALL be discarded (comb warm-up): no load and no sample_valid.
REQ-019 sample and sample_valid SHALL hold steady while sample_valid = 1 and sample_ready = 0, unless a new result arrives (REQ-021).
REQ-020 On a cycle with sample_valid = 1, sample_ready = 1 and no new result, sample_valid SHALL clear at the next edge.
REQ-021 A new result arriving while sample_valid = 1 and sample_ready = 0 SHALL overwrite sample, keep sample_valid = 1 and set overrun.
REQ-022 A new result arriving in the same cycle as a handshake SHALL load, keep sample_valid = 1 and leave overrun unchanged.
REQ-023 overrun SHALL stay set until reset.
REQ-024 bit_en may be high on every cycle; back-to-back ticks every R cycles SHALL be supported with no lost results.

Reset
REQ-025 With reset low at a clk edge, the block SHALL clear integrators, combs, decimation counter and warm-up counter to 0, and set sample = 0, sample_valid = 0 and overrun = 0.
REQ-026 A reset mid-frame SHALL abandon the partial frame; the first output after release SHALL follow REQ-018.
REQ-027 Reset SHALL take priority over all other inputs, including bit_en and sample_ready.

Verification
REQ-028 Defaults, bit_en always 1, pdm_in constant 1, sample_ready = 1 -> after warm-up every output = 255 (y = 1024 saturated), one per 32 cycles.
REQ-029 pdm_in constant 0 -> every output after warm-up = 0; overrun stays 0.
REQ-030 pdm_in alternating 1,0 -> outputs = 128; pattern 1,0,0,0 -> outputs = 64.
REQ-031 bit_en high one cycle in four, pdm_in = 1 -> outputs = 255 every 128 clk cycles; latency exactly 2 cycles after the tick.
REQ-032 Hold sample_ready = 0 across two results -> second value overwrites, sample_valid stays 1, overrun = 1 until reset; ready asserted on a new-result cycle -> no overrun.
REQ-033 Assert reset low mid-frame with sample_valid = 1 -> next edge gives sample = 0, sample_valid = 0, overrun = 0; the next 2 results are suppressed.

Source files
------------

// File: rtl/pdm_demod.sv
`default_nettype none
// ============================================================================
// Module      : pdm_demod
// Description : Unipolar PDM to PCM demodulator using a 2nd-order CIC
//               decimator with saturating scaling and a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_demod #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int DEC_LOG2     = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pdm_in,
    input  logic                    bit_en,
    output logic [OUTPUT_WIDTH-1:0] sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun
);

    localparam int                  c_W          = 2 * DEC_LOG2 + 1;
    localparam int                  c_SHIFT      = 2 * DEC_LOG2 - OUTPUT_WIDTH;
    localparam logic [DEC_LOG2-1:0] c_CNT_LAST   = '1;
    localparam logic [1:0]          c_WARM_DONE  = 2'd2;

    logic [c_W-1:0]          r_integ1;
    logic [c_W-1:0]          r_integ2;
    logic [c_W-1:0]          r_comb1_dly;
    logic [c_W-1:0]          r_comb2_dly;
    logic [c_W-1:0]          r_y;
    logic [DEC_LOG2-1:0]     r_dec_cnt;
    logic [1:0]              r_warm_cnt;
    logic                    r_tick_d;
    logic                    r_y_valid;

    logic                    w_tick;
    logic [c_W-1:0]          w_comb1;
    logic [c_W-1:0]          w_comb2;
    logic [c_W-1:0]          w_shifted;
    logic                    w_sat;
    logic [OUTPUT_WIDTH-1:0] w_scaled;

    assign w_tick = bit_en && (r_dec_cnt == c_CNT_LAST);

    // Integrator 2 accumulates integrator 1's value from before this update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_integ1  <= '0;
            r_integ2  <= '0;
            r_dec_cnt <= '0;
        end else if (bit_en) begin
            r_integ1  <= r_integ1 + {{(c_W-1){1'b0}}, pdm_in};
            r_integ2  <= r_integ2 + r_integ1;
            r_dec_cnt <= r_dec_cnt + 1'b1;
        end
    end

    assign w_comb1 = r_integ2 - r_comb1_dly;
    assign w_comb2 = w_comb1 - r_comb2_dly;

    // The first two comb outputs are built on empty delay lines and are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_d    <= 1'b0;
            r_comb1_dly <= '0;
            r_comb2_dly <= '0;
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_warm_cnt  <= '0;
        end else begin
            r_tick_d  <= w_tick;
            r_y_valid <= 1'b0;
            if (r_tick_d) begin
                r_comb1_dly <= r_integ2;
                r_comb2_dly <= w_comb1;
                r_y         <= w_comb2;
                if (r_warm_cnt == c_WARM_DONE) begin
                    r_y_valid <= 1'b1;
                end else begin
                    r_warm_cnt <= r_warm_cnt + 1'b1;
                end
            end
        end
    end

    assign w_shifted = r_y >> c_SHIFT;
    assign w_sat     = |w_shifted[c_W-1:OUTPUT_WIDTH];
    assign w_scaled  = w_sat ? {OUTPUT_WIDTH{1'b1}} : w_shifted[OUTPUT_WIDTH-1:0];

    // A new result always wins over a handshake; overrun only if it was unread.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (r_y_valid) begin
            sample       <= w_scaled;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_demod
// Description : Self-checking bench for pdm_demod (vector table, corner
//               sequences and randomized traffic against a frame-level model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_demod;

    localparam int OUTPUT_WIDTH = 8;
    localparam int DEC_LOG2     = 5;
    localparam int R            = 1 << DEC_LOG2;
    localparam int SHIFT        = 2 * DEC_LOG2 - OUTPUT_WIDTH;
    localparam int SMAX         = (1 << OUTPUT_WIDTH) - 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    pdm_in = 1'b0;
    logic                    bit_en = 1'b0;
    logic                    sample_ready = 1'b0;
    logic [OUTPUT_WIDTH-1:0] sample;
    logic                    sample_valid;
    logic                    overrun;

    pdm_demod #(
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .DEC_LOG2    (DEC_LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pdm_in      (pdm_in),
        .bit_en      (bit_en),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a CIC2 output equals a triangular FIR over the last two
    // frames -- weights p+1 over the previous frame, R-1-p over the current one.
    typedef struct {
        int due;
        int value;
    } pend_t;

    int    cur_bits[R];
    int    prev_bits[R];
    int    pos;
    int    frames;
    pend_t pend[$];
    int    m_sample;
    int    m_valid;
    int    m_overrun;
    int    loads = 0;
    bit    load_now;

    function automatic int frame_y();
        int y;
        y = 0;
        for (int p = 0; p < R; p++) begin
            y += prev_bits[p] * (p + 1) + cur_bits[p] * (R - 1 - p);
        end
        return y;
    endfunction

    function automatic int scale(int y);
        int s;
        s = y >> SHIFT;
        return (s > SMAX) ? SMAX : s;
    endfunction

    task automatic model_edge(bit rst_n, bit pdm, bit en, bit rdy);
        pend_t pe;
        load_now = 1'b0;
        if (!rst_n) begin
            pos = 0; frames = 0;
            for (int p = 0; p < R; p++) begin
                cur_bits[p] = 0; prev_bits[p] = 0;
            end
            pend.delete();
            m_sample = 0; m_valid = 0; m_overrun = 0;
            return;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            pe = pend.pop_front();
            if (m_valid != 0 && !rdy) m_overrun = 1;
            m_sample = pe.value;
            m_valid  = 1;
            load_now = 1'b1;
            loads++;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
        if (en) begin
            cur_bits[pos] = pdm ? 1 : 0;
            pos++;
            if (pos == R) begin
                frames++;
                pe.value = scale(frame_y());
                pe.due   = cyc + 2;
                for (int p = 0; p < R; p++) prev_bits[p] = cur_bits[p];
                pos = 0;
                if (frames >= 3) pend.push_back(pe);
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(bit rst_n, bit pdm, bit en, bit rdy);
        reset = rst_n; pdm_in = pdm; bit_en = en; sample_ready = rdy;
        @(posedge clk);
        cyc++;
        model_edge(rst_n, pdm, en, rdy);
        @(negedge clk);
        check("valid", int'(sample_valid), m_valid);
        check("overrun", int'(overrun), m_overrun);
        check("sample", int'(sample), m_sample);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_overrun", int'(overrun), 0);
    endtask

    typedef struct {
        logic [7:0] pat;
        int         plen;
        int         period;
        int         nframes;
        int         exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  bi, start, prev_load, tick_cyc, nbits;
        bit  en, p, rdy, first, rst_n;
        int  dens, en_prob, rdy_prob;

        vecs[0] = '{8'h01, 1, 1, 6, 255};
        vecs[1] = '{8'h00, 1, 1, 6, 0};
        vecs[2] = '{8'h01, 2, 1, 6, 128};
        vecs[3] = '{8'h01, 4, 1, 6, 64};
        vecs[4] = '{8'h01, 1, 4, 5, 255};
        vecs[5] = '{8'h03, 4, 2, 5, 128};

        do_reset();

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bi = 0; start = loads; first = 1'b1; prev_load = 0; tick_cyc = 0;
            nbits = vecs[v].nframes * R * vecs[v].period;
            for (int c = 0; c < nbits + 4; c++) begin
                en = (c < nbits) && (c % vecs[v].period == vecs[v].period - 1);
                p  = vecs[v].pat[bi % vecs[v].plen];
                step(1'b1, p, en, 1'b1);
                if (en) begin
                    bi++;
                    if (bi % R == 0) tick_cyc = cyc;
                end
                if (load_now) begin
                    check("table_value", int'(sample), vecs[v].exp);
                    check("table_latency", cyc - tick_cyc, 2);
                    if (!first) check("table_interval", cyc - prev_load, R * vecs[v].period);
                    first = 1'b0;
                    prev_load = cyc;
                end
            end
            check("table_loads", loads - start, vecs[v].nframes - 2);
        end

        // Unread results get overwritten; the flag sticks after draining.
        do_reset();
        for (int c = 0; c < 5 * R + 3; c++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_valid", int'(sample_valid), 1);
        check("ovr_sample", int'(sample), 255);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("ovr_drain_valid", int'(sample_valid), 0);
        check("ovr_sticky", int'(overrun), 1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("ovr_sticky_late", int'(overrun), 1);

        // Ready only on the cycle a new result lands: never an overrun.
        do_reset();
        start = loads;
        for (int c = 0; c < 6 * R + 3; c++) begin
            rdy = (pend.size() > 0) && (pend[0].due == cyc + 1);
            step(1'b1, 1'b1, 1'b1, rdy);
        end
        check("nr_overrun", int'(overrun), 0);
        check("nr_valid", int'(sample_valid), 1);
        check("nr_loads", loads - start, 4);

        // Mid-frame reset with a pending sample, then warm-up suppression.
        do_reset();
        for (int c = 0; c < 3 * R + 12; c++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("mr_pre_valid", int'(sample_valid), 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("mr_sample", int'(sample), 0);
        check("mr_valid", int'(sample_valid), 0);
        check("mr_overrun", int'(overrun), 0);
        start = loads;
        for (int c = 0; c < 2 * R + 4; c++) step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mr_warm_suppress", loads - start, 0);
        check("mr_warm_valid", int'(sample_valid), 0);
        for (int c = 0; c < R; c++) step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mr_first_load", loads - start, 1);
        check("mr_first_value", int'(sample), 255);

        // Randomized traffic with occasional resets.
        do_reset();
        dens = 50; en_prob = 100; rdy_prob = 50;
        for (int c = 0; c < 20000; c++) begin
            if (c % 600 == 0) begin
                dens     = $urandom_range(0, 100);
                en_prob  = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(10, 100);
                rdy_prob = $urandom_range(0, 100);
            end
            rst_n = ($urandom_range(0, 2999) != 0);
            p     = ($urandom_range(0, 99) < dens);
            en    = ($urandom_range(0, 99) < en_prob);
            rdy   = ($urandom_range(0, 99) < rdy_prob);
            step(rst_n, p, en, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
